// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot-or-zero grant, per-owner hold timeout and one idle cycle between grants.
// Latency: grant visible one edge after the request is seen; the only backpressure is the single-owner grant itself.
module rr_grant_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           timeout
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]     r_state;
   logic [IDW-1:0] r_ptr;
   logic [7:0]     r_hold_cnt;
   logic [N-1:0]   r_gnt;
   logic [IDW-1:0] r_gnt_id;
   logic           r_timeout;

   logic           w_sel_vld;
   logic [IDW-1:0] w_sel_idx;
   logic [IDW-1:0] w_next_ptr;
   logic           w_owner_req;
   logic           w_expired;

   function automatic logic [IDW-1:0] f_rot(input logic [IDW-1:0] base, input int k);
      int j;
      j = (int'(base) + k) % N;
      return IDW'(j);
   endfunction

   // Scan from the far end of the rotation so the slot closest to r_ptr wins.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[f_rot(r_ptr, k)]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = f_rot(r_ptr, k);
         end
      end
   end

   assign w_next_ptr  = (int'(r_gnt_id) == N - 1) ? '0 : r_gnt_id + 1'b1;
   assign w_owner_req = req[r_gnt_id];
   assign w_expired   = (r_hold_cnt == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_timeout <= 1'b0;
               if (w_sel_vld) begin
                  r_gnt      <= N'(1) << w_sel_idx;
                  r_gnt_id   <= w_sel_idx;
                  r_hold_cnt <= '0;
                  r_state    <= ST_GRANT;
               end
            end
            default: begin
               if (!w_owner_req || w_expired) begin
                  // Release takes precedence over expiry, so timeout only fires when req is still held.
                  r_gnt     <= '0;
                  r_gnt_id  <= '0;
                  r_ptr     <= w_next_ptr;
                  r_state   <= ST_IDLE;
                  r_timeout <= w_owner_req;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
                  r_timeout  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign busy    = |r_gnt;
   assign timeout = r_timeout;

endmodule
